// File: rtl/dlc_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : dlc_supervisor
// Purpose  : Sequencing supervisor for the X->Y->X->X->Y lock FSM. It gates
//            the keypad, times entry attempts, enforces lockout and drives
//            auto-relock. Optional ALARM output is enabled with DLC_ALARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dlc_supervisor #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int TICK_HZ       = 1,
  parameter int ATTEMPT_TICKS = 10,
  parameter int MAX_FAILS     = 3,
  parameter int LOCKOUT_TICKS = 30,
  parameter int RELOCK_TICKS  = 15
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       X_IN,
  input  logic       Y_IN,
  input  logic       LOCK_REQ,
  input  logic       UNLOCK_IN,
  output logic       X_OUT,
  output logic       Y_OUT,
  output logic       LOCK_OUT,
  output logic       RED,
  output logic [2:0] FAILS,
  output logic [1:0] STATE
`ifdef DLC_ALARM_EN
  ,
  output logic       ALARM
`endif
);

  localparam int             c_DIV     = CLK_HZ / TICK_HZ;
  localparam int             c_CNT_W   = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DIV - 1);
  localparam logic [7:0]     c_ATTEMPT = 8'(ATTEMPT_TICKS);
  localparam logic [7:0]     c_LOCKOUT = 8'(LOCKOUT_TICKS);
  localparam logic [7:0]     c_RELOCK  = 8'(RELOCK_TICKS);
  localparam logic [2:0]     c_MAX     = 3'(MAX_FAILS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTRY   = 2'd1,
    S_OPEN    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_tick_cnt;
  logic [7:0]           r_timer;
  logic [2:0]           r_fails;
  logic [1:0]           r_strobe;
  logic                 r_unlock_d;
  logic                 w_tick;
  logic                 w_rise;
  logic                 w_lockout;
  logic [2:0]           w_fails_inc;
`ifdef DLC_ALARM_EN
  logic                 r_alarm;
`endif

  assign w_tick      = (r_tick_cnt == c_CNT_LAST);
  assign w_rise      = UNLOCK_IN & ~r_unlock_d;
  assign w_lockout   = (r_state == S_LOCKOUT);
  assign w_fails_inc = r_fails + 3'd1;

  // Free-running timebase; state changes never disturb its phase.
  always_ff @(negedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_tick_cnt <= '0;
      r_unlock_d <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_unlock_d <= UNLOCK_IN;
    end
  end

  always_ff @(negedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state  <= S_IDLE;
      r_timer  <= 8'd0;
      r_fails  <= 3'd0;
      r_strobe <= 2'd0;
`ifdef DLC_ALARM_EN
      r_alarm  <= 1'b0;
`endif
    end else begin
      // Background counting; transition branches below override these.
      if (w_tick && r_timer != 8'hFF) r_timer <= r_timer + 8'd1;
      if (w_tick && r_strobe != 2'd0) r_strobe <= r_strobe - 2'd1;
`ifdef DLC_ALARM_EN
      if (w_tick && w_lockout) r_alarm <= ~r_alarm;
`endif
      case (r_state)
        S_IDLE: begin
          if (X_IN | Y_IN) begin
            r_state <= S_ENTRY;
            r_timer <= 8'd0;
          end
        end
        S_ENTRY: begin
          if (LOCK_REQ) begin
            r_state <= S_IDLE;
            r_timer <= 8'd0;
          end else if (w_rise) begin
            r_state <= S_OPEN;
            r_timer <= 8'd0;
            r_fails <= 3'd0;
          end else if (r_timer == c_ATTEMPT) begin
            r_state  <= (w_fails_inc == c_MAX) ? S_LOCKOUT : S_IDLE;
            r_timer  <= 8'd0;
            r_fails  <= w_fails_inc;
            r_strobe <= 2'd2;
          end
        end
        S_OPEN: begin
          if (LOCK_REQ || !UNLOCK_IN) begin
            r_state <= S_IDLE;
            r_timer <= 8'd0;
          end else if (r_timer == c_RELOCK) begin
            r_state  <= S_IDLE;
            r_timer  <= 8'd0;
            r_strobe <= 2'd2;
          end
        end
        S_LOCKOUT: begin
          if (r_timer == c_LOCKOUT) begin
            r_state <= S_IDLE;
            r_timer <= 8'd0;
            r_fails <= 3'd0;
`ifdef DLC_ALARM_EN
            r_alarm <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  assign STATE    = r_state;
  assign FAILS    = r_fails;
  assign RED      = w_lockout;
  assign LOCK_OUT = (r_strobe != 2'd0) | LOCK_REQ | w_lockout;
  assign X_OUT    = X_IN & ~w_lockout;
  assign Y_OUT    = Y_IN & ~w_lockout;
`ifdef DLC_ALARM_EN
  assign ALARM    = r_alarm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dlc_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_dlc_supervisor
// Purpose  : Directed table, hand sequences and random run against a
//            reference model for dlc_supervisor (DLC_ALARM_EN optional).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dlc_supervisor;

  localparam int c_CLK_HZ  = 4;
  localparam int c_TICK_HZ = 1;
  localparam int c_ATTEMPT = 3;
  localparam int c_MAXF    = 2;
  localparam int c_LOCKOUT = 5;
  localparam int c_RELOCK  = 4;
  localparam int c_DIV     = c_CLK_HZ / c_TICK_HZ;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic       X_IN = 1'b0, Y_IN = 1'b0, LOCK_REQ = 1'b0, UNLOCK_IN = 1'b0;
  logic       X_OUT, Y_OUT, LOCK_OUT, RED;
  logic [2:0] FAILS;
  logic [1:0] STATE;
  logic       alarm_v;
`ifdef DLC_ALARM_EN
  logic       ALARM;
  assign alarm_v = ALARM;
`else
  assign alarm_v = 1'b0;
`endif

  dlc_supervisor #(
    .CLK_HZ(c_CLK_HZ), .TICK_HZ(c_TICK_HZ), .ATTEMPT_TICKS(c_ATTEMPT),
    .MAX_FAILS(c_MAXF), .LOCKOUT_TICKS(c_LOCKOUT), .RELOCK_TICKS(c_RELOCK)
  ) u_dut (
    .CLK(CLK), .nRESET(nRESET), .X_IN(X_IN), .Y_IN(Y_IN),
    .LOCK_REQ(LOCK_REQ), .UNLOCK_IN(UNLOCK_IN), .X_OUT(X_OUT), .Y_OUT(Y_OUT),
    .LOCK_OUT(LOCK_OUT), .RED(RED), .FAILS(FAILS), .STATE(STATE)
`ifdef DLC_ALARM_EN
    , .ALARM(ALARM)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       x, lreq, unl;
    int         n;
    logic [1:0] st;
    logic [2:0] fl;
    logic       lk, rd, xo, al;
  } row_t;
  row_t rows[$];

  task automatic add(input logic x, lreq, unl, input int n, input logic [1:0] st,
                     input logic [2:0] fl, input logic lk, rd, xo, al);
    row_t r;
    r.x = x; r.lreq = lreq; r.unl = unl; r.n = n; r.st = st; r.fl = fl;
    r.lk = lk; r.rd = rd; r.xo = xo; r.al = al;
    rows.push_back(r);
  endtask

  task automatic check(input string name, input logic [1:0] st, input logic [2:0] fl,
                       input logic lk, rd, xo, yo, al);
    logic ok;
    ok = (STATE === st) && (FAILS === fl) && (LOCK_OUT === lk) && (RED === rd)
         && (X_OUT === xo) && (Y_OUT === yo);
`ifdef DLC_ALARM_EN
    ok = ok && (alarm_v === al);
`endif
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s @%0t: got STATE=%0d FAILS=%0d LOCK_OUT=%0b RED=%0b X_OUT=%0b Y_OUT=%0b ALARM=%0b, required %0d %0d %0b %0b %0b %0b %0b",
               name, $time, STATE, FAILS, LOCK_OUT, RED, X_OUT, Y_OUT, alarm_v,
               st, fl, lk, rd, xo, yo, al);
    end
  endtask

  // Reference model: counts of ticks since state entry and ticks spent in lockout.
  int m_state, m_fails, m_timer, m_strobe, m_cnt, m_lock_ticks;
  bit m_unl_prev;

  task automatic model_reset();
    m_state = 0; m_fails = 0; m_timer = 0; m_strobe = 0;
    m_cnt = 0; m_lock_ticks = 0; m_unl_prev = 0;
  endtask

  task automatic model_step(input bit x, y, lreq, unl);
    bit tick, rise, arm;
    int ns;
    tick = (m_cnt == c_DIV - 1);
    rise = unl && !m_unl_prev;
    arm  = 0;
    ns   = m_state;
    case (m_state)
      0: if (x || y) ns = 1;
      1: begin
        if (lreq) ns = 0;
        else if (rise) begin ns = 2; m_fails = 0; end
        else if (m_timer == c_ATTEMPT) begin
          m_fails = m_fails + 1;
          arm = 1;
          ns = (m_fails == c_MAXF) ? 3 : 0;
        end
      end
      2: begin
        if (lreq || !unl) ns = 0;
        else if (m_timer == c_RELOCK) begin arm = 1; ns = 0; end
      end
      default: if (m_timer == c_LOCKOUT) begin ns = 0; m_fails = 0; end
    endcase
    if (ns != m_state) begin
      m_timer = 0;
      m_lock_ticks = 0;
    end else if (tick) begin
      m_timer = (m_timer < 255) ? m_timer + 1 : 255;
      if (m_state == 3) m_lock_ticks++;
    end
    if (arm) m_strobe = 2;
    else if (tick && m_strobe > 0) m_strobe--;
    m_cnt = (m_cnt + 1) % c_DIV;
    m_unl_prev = unl;
    m_state = ns;
  endtask

  task automatic check_model(input string name);
    bit lk;
    lk = (m_strobe != 0) || LOCK_REQ || (m_state == 3);
    check(name, 2'(m_state), 3'(m_fails), lk, m_state == 3,
          X_IN && m_state != 3, Y_IN && m_state != 3,
          (m_state == 3) && (m_lock_ticks % 2 == 1));
  endtask

  initial begin
    bit found;
    bit unl_r;

    // ---- Reset mid-count ----
    repeat (2) @(posedge CLK);
    nRESET = 1'b1;
    repeat (6) @(posedge CLK);
    X_IN = 1'b1;
    #2 nRESET = 1'b0;
    #1 check("reset_mid_count", 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    X_IN = 1'b0;
    #1 check("reset_x_track", 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);

    // ---- Directed table (cycle 0 starts at reset release) ----
    add(0,0,0,  2, 0,0,0,0,0,0);  // c0-1 idle
    add(1,0,0,  1, 0,0,0,0,1,0);  // c2 press
    add(0,0,0,  5, 1,0,0,0,0,0);  // c3-7 entry
    add(0,0,1,  1, 1,0,0,0,0,0);  // c8 unlock rise at tick 2
    add(0,0,1,  1, 2,0,0,0,0,0);  // c9 open
    add(0,0,1, 15, 2,0,0,0,0,0);  // c10-24 held open
    add(0,0,0,  1, 0,0,1,0,0,0);  // c25 relock strobe
    add(0,0,0,  6, 0,0,1,0,0,0);  // c26-31
    add(0,0,0,  1, 0,0,0,0,0,0);  // c32 strobe ends
    add(1,0,0,  1, 0,0,0,0,1,0);  // c33 press
    add(0,0,0, 11, 1,0,0,0,0,0);  // c34-44
    add(0,0,0,  1, 0,1,1,0,0,0);  // c45 first failure
    add(0,0,0,  6, 0,1,1,0,0,0);  // c46-51
    add(0,0,0,  1, 0,1,0,0,0,0);  // c52
    add(1,0,0,  1, 0,1,0,0,1,0);  // c53 press
    add(0,0,0, 11, 1,1,0,0,0,0);  // c54-64
    add(1,0,0,  1, 3,2,1,1,0,0);  // c65 lockout, X gated
    add(1,0,0, 19, 3,2,1,1,0,1);  // c66-84 five alarm toggles
    add(0,0,0,  1, 0,0,0,0,0,0);  // c85 released
    add(1,0,0,  1, 0,0,0,0,1,0);  // c86 press
    add(0,0,0, 10, 1,0,0,0,0,0);  // c87-96
    add(1,0,0,  1, 0,1,1,0,1,0);  // c97 failure, press again
    add(0,1,1,  1, 1,1,1,0,0,0);  // c98 LOCK_REQ beats unlock rise
    add(0,0,1,  1, 0,1,1,0,0,0);  // c99 back in idle, FAILS kept
    add(0,0,0,  8, 0,1,0,0,0,0);  // c100-107

    nRESET = 1'b1;
    foreach (rows[i]) begin
      for (int k = 0; k < rows[i].n; k++) begin
        X_IN = rows[i].x; LOCK_REQ = rows[i].lreq; UNLOCK_IN = rows[i].unl; Y_IN = 1'b0;
        #1;
        if (k == rows[i].n - 1)
          check($sformatf("row%0d", i), rows[i].st, rows[i].fl, rows[i].lk,
                rows[i].rd, rows[i].xo, 1'b0, rows[i].al);
        @(posedge CLK);
      end
    end

    // ---- Reset in the middle of lockout ----
    X_IN = 1'b1;
    @(posedge CLK);
    X_IN = 1'b0;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(posedge CLK);
      #1 if (STATE == 2'd3) found = 1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL lockout_wait: STATE=%0d, required 3 within 60 cycles", STATE);
    end
    Y_IN = 1'b1;
    #1 check("lockout_gate_y", 2'd3, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, alarm_v);
    nRESET = 1'b0;
    #1 check("reset_in_lockout", 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    Y_IN = 1'b0;
    @(posedge CLK);

    // ---- Random run against the model ----
    model_reset();
    nRESET = 1'b1;
    unl_r = 0;
    for (int c = 0; c < 4000; c++) begin
      X_IN = ($urandom_range(0, 7) == 0);
      Y_IN = ($urandom_range(0, 9) == 0);
      LOCK_REQ = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 14) == 0) unl_r = !unl_r;
      UNLOCK_IN = unl_r;
      if ($urandom_range(0, 599) == 0) begin
        nRESET = 1'b0;
        model_reset();
        #1 check_model("rand_reset");
        #1 nRESET = 1'b1;
      end else begin
        #1 check_model("rand");
      end
      @(negedge CLK);
      model_step(X_IN, Y_IN, LOCK_REQ, UNLOCK_IN);
      @(posedge CLK);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
